// File: rtl/pixel_load_sequencer_if.sv
// FIFO, image-memory and SDRAM flow-control signals of the pixel load sequencer.
// master = the sequencer, slave = the FIFO / memory / SDRAM side.
interface pixel_load_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              fifo_empty;
  logic [15:0]       fifo_dout;
  logic              fifo_hw;
  logic              fifo_lw;
  logic              fifo_pop;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_din;
  logic              sdram_pause;
  logic              sdram_unpause;

  modport master (
    input  fifo_empty, fifo_dout, fifo_hw, fifo_lw,
    output fifo_pop, mem_we, mem_addr, mem_din, sdram_pause, sdram_unpause
  );

  modport slave (
    output fifo_empty, fifo_dout, fifo_hw, fifo_lw,
    input  fifo_pop, mem_we, mem_addr, mem_din, sdram_pause, sdram_unpause
  );
endinterface

// File: rtl/pixel_load_sequencer.sv
// Pixel load sequencer: pops 16-bit FIFO words, repacks every three words into
// two 24-bit pixels (big-endian), writes them to consecutive image-memory
// addresses and throttles the SDRAM reader from the FIFO watermarks.
//
// state  | meaning
// S_IDLE | waiting for start, SDRAM paused
// S_LOAD | popping words and writing pixels
// S_DONE | all pixels written, waiting for start or abort
module pixel_load_sequencer #(
  parameter int N_PIXELS = 512,
  parameter int ADDR_W   = 9
) (
  input  logic                   clk50_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  pixel_load_sequencer_if.master bus,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int N_WORDS = 3 * N_PIXELS / 2;
  localparam int WCNT_W  = $clog2(N_WORDS + 1);
  localparam int PCNT_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);
  localparam logic [WCNT_W-1:0] WORDS_MAX = WCNT_W'(N_WORDS);
  localparam logic [PCNT_W-1:0] PIX_MAX   = PCNT_W'(N_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [15:0]         hold_q, hold_d;
  logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [23:0]         mem_din_q, mem_din_d;
  logic                pause_q, pause_d;
  logic                unpause_q, unpause_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pop;
  logic                enter_load;

  // Pop the FIFO head whenever a load is running and words are still owed;
  // abort suppresses the pop so no word is lost into a discarded load.
  always_comb begin
    pop = (state_q == S_LOAD) && !bus.fifo_empty && (word_cnt_q < WORDS_MAX) && !abort_i;
  end

  // Next-state logic; abort has priority over start and completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (abort_i)      state_d = S_IDLE;
        else if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (abort_i)                                   state_d = S_IDLE;
        else if (mem_we_q && (mem_addr_q == LAST_ADDR)) state_d = S_DONE;
      end
      S_DONE: begin
        if (abort_i)      state_d = S_IDLE;
        else if (start_i) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
    enter_load = (state_q != S_LOAD) && (state_d == S_LOAD);
  end

  // Repacking datapath, counters and registered outputs.
  always_comb begin
    phase_d    = phase_q;
    hold_d     = hold_q;
    pix_cnt_d  = pix_cnt_q;
    word_cnt_d = word_cnt_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    if (enter_load) begin
      phase_d    = 2'd0;
      hold_d     = 16'h0000;
      pix_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (pop) begin
      word_cnt_d = word_cnt_q + 1'b1;
      case (phase_q)
        2'd1: begin
          // Second word completes the even pixel; its low byte starts the odd one.
          if (pix_cnt_q < PIX_MAX) begin
            mem_we_d   = 1'b1;
            mem_addr_d = pix_cnt_q[ADDR_W-1:0];
            mem_din_d  = {hold_q, bus.fifo_dout[15:8]};
            pix_cnt_d  = pix_cnt_q + 1'b1;
          end
          hold_d[7:0] = bus.fifo_dout[7:0];
          phase_d     = 2'd2;
        end
        2'd2: begin
          if (pix_cnt_q < PIX_MAX) begin
            mem_we_d   = 1'b1;
            mem_addr_d = pix_cnt_q[ADDR_W-1:0];
            mem_din_d  = {hold_q[7:0], bus.fifo_dout};
            pix_cnt_d  = pix_cnt_q + 1'b1;
          end
          phase_d = 2'd0;
        end
        default: begin
          hold_d  = bus.fifo_dout;
          phase_d = 2'd1;
        end
      endcase
    end

    pause_d   = (state_d != S_LOAD) || bus.fifo_hw;
    unpause_d = (state_d == S_LOAD) && bus.fifo_lw && !bus.fifo_hw;
    busy_d    = (state_d == S_LOAD);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk50_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      phase_q    <= 2'd0;
      hold_q     <= 16'h0000;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 24'h000000;
      pause_q    <= 1'b1;
      unpause_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      pause_q    <= pause_d;
      unpause_q  <= unpause_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Output drives.
  always_comb begin
    bus.fifo_pop      = pop;
    bus.mem_we        = mem_we_q;
    bus.mem_addr      = mem_addr_q;
    bus.mem_din       = mem_din_q;
    bus.sdram_pause   = pause_q;
    bus.sdram_unpause = unpause_q;
    busy_o            = busy_q;
    done_o            = done_q;
  end

endmodule

// File: tb/tb_pixel_load_sequencer.sv
// Directed-plus-random bench for pixel_load_sequencer with a byte-stream
// reference model of the load: pixel k is bytes 3k..3k+2 of the popped words.
module tb_pixel_load_sequencer;
  localparam int N_PIXELS = 512;
  localparam int ADDR_W   = 9;
  localparam int N_WORDS  = 3 * N_PIXELS / 2;

  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic reset_i, start_i, abort_i;
  logic busy_o, done_o;

  pixel_load_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pixel_load_sequencer #(.N_PIXELS(N_PIXELS), .ADDR_W(ADDR_W)) dut (
    .clk50_i (clk50),
    .reset_i (reset_i),
    .start_i (start_i),
    .abort_i (abort_i),
    .bus     (bus),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  int checks = 0;
  int errors = 0;

  // model state
  bit              m_load, m_done, m_we;
  int              m_pops, m_writes;
  logic [ADDR_W-1:0] m_addr;
  logic [23:0]     m_din;
  logic [7:0]      pb[$];
  logic [15:0]     fq[$];
  logic [15:0]     ld[$];
  bit              stall;
  int              cyc, last_wr_cyc, total_pops, wr_count;
  int              first_wr_addr, last_wr_addr;
  logic [23:0]     tb_mem[N_PIXELS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int idx);
    logic [15:0] w;
    w = ld[idx / 2];
    return (idx % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic drive_fifo();
    bus.fifo_empty = stall || (fq.size() == 0);
    bus.fifo_dout  = (fq.size() != 0) ? fq[0] : 16'h0000;
  endtask

  // One clock cycle: inputs are already set; predict, clock, compare.
  task automatic cycle();
    bit exp_pop, n_load, n_done, n_we, n_pause, n_unp;
    logic [15:0] w;
    int k;
    drive_fifo();
    @(negedge clk50);
    exp_pop = m_load && !bus.fifo_empty && (m_pops < N_WORDS) && !abort_i;
    chk("fifo_pop", bus.fifo_pop, exp_pop);
    n_we = 0;
    if (reset_i) begin
      n_load = 0; n_done = 0;
      m_pops = 0; m_writes = 0;
      m_addr = '0; m_din = '0;
    end else begin
      if (exp_pop) begin
        w = fq[0];
        pb.push_back(w[15:8]);
        pb.push_back(w[7:0]);
        if (m_pops % 3 != 0) n_we = 1;
        m_pops++;
      end
      if (abort_i) begin
        n_load = 0; n_done = 0;
      end else if (m_load) begin
        if (m_we && (m_addr == ADDR_W'(N_PIXELS - 1))) begin
          n_load = 0; n_done = 1;
        end else begin
          n_load = 1; n_done = 0;
        end
      end else if (start_i) begin
        n_load = 1; n_done = 0;
        m_pops = 0; m_writes = 0;
        pb.delete();
      end else begin
        n_load = 0; n_done = m_done;
      end
      if (n_we) begin
        k = m_writes;
        m_addr = ADDR_W'(k);
        m_din  = {pb[3*k], pb[3*k+1], pb[3*k+2]};
        m_writes++;
      end
    end
    n_pause = !n_load || bus.fifo_hw;
    n_unp   = n_load && bus.fifo_lw && !bus.fifo_hw;
    @(posedge clk50);
    cyc++;
    if (exp_pop && !reset_i) begin
      void'(fq.pop_front());
      total_pops++;
    end
    m_load = n_load; m_done = n_done; m_we = n_we;
    #1;
    chk("mem_we", bus.mem_we, m_we);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_din", bus.mem_din, m_din);
    chk("busy", busy_o, n_load);
    chk("done", done_o, n_done);
    chk("sdram_pause", bus.sdram_pause, n_pause);
    chk("sdram_unpause", bus.sdram_unpause, n_unp);
    if (bus.mem_we === 1'b1) begin
      tb_mem[bus.mem_addr] = bus.mem_din;
      if (wr_count == 0) first_wr_addr = int'(bus.mem_addr);
      last_wr_addr = int'(bus.mem_addr);
      last_wr_cyc  = cyc;
      wr_count++;
    end
  endtask

  task automatic rand_inputs(input bit allow_stall);
    stall = allow_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    bus.fifo_hw = ($urandom_range(0, 3) == 0);
    bus.fifo_lw = ($urandom_range(0, 1) == 0);
  endtask

  task automatic fill_fifo(input int n);
    logic [15:0] w;
    fq.delete();
    ld.delete();
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      fq.push_back(w);
      ld.push_back(w);
    end
  endtask

  initial begin
    int n;
    reset_i = 1; start_i = 0; abort_i = 0; stall = 0;
    bus.fifo_hw = 0; bus.fifo_lw = 0;
    m_load = 0; m_done = 0; m_we = 0; m_pops = 0; m_writes = 0;
    m_addr = '0; m_din = '0;
    cyc = 0; last_wr_cyc = 0; total_pops = 0; wr_count = 0;
    first_wr_addr = -1; last_wr_addr = -1;
    for (int i = 0; i < N_PIXELS; i++) tb_mem[i] = 24'h0;
    drive_fifo();
    @(posedge clk50); #1;

    // reset and idle
    cycle();
    cycle();
    reset_i = 0;
    fill_fifo(10);
    for (int i = 0; i < 6; i++) begin
      rand_inputs(0);
      cycle();
    end
    chk("idle_pause", bus.sdram_pause, 1'b1);
    chk("idle_no_pops", total_pops, 0);

    // packing with a known three-word stream
    fq.delete();
    fq.push_back(16'h1122); fq.push_back(16'h3344); fq.push_back(16'h5566);
    bus.fifo_hw = 0; bus.fifo_lw = 0; stall = 0;
    start_i = 1; cycle(); start_i = 0;
    for (int i = 0; i < 5; i++) cycle();
    chk("pack_addr0", tb_mem[0], 24'h112233);
    chk("pack_addr1", tb_mem[1], 24'h445566);
    abort_i = 1; cycle(); abort_i = 0;
    chk("pack_abort_busy", busy_o, 1'b0);

    // full load with random stalls and watermarks
    fill_fifo(800);
    for (int i = 0; i < N_PIXELS; i++) tb_mem[i] = 24'h0;
    total_pops = 0; wr_count = 0;
    start_i = 1; cycle(); start_i = 0;
    n = 0;
    while (!done_o && n < 5000) begin
      rand_inputs(1);
      cycle();
      n++;
    end
    chk("full_done", done_o, 1'b1);
    chk("full_pops", total_pops, N_WORDS);
    chk("full_writes", wr_count, N_PIXELS);
    chk("full_last_addr", last_wr_addr, N_PIXELS - 1);
    chk("done_latency", cyc - last_wr_cyc, 1);
    for (int k = 0; k < N_PIXELS; k++)
      chk("full_pixel", tb_mem[k], {byte_of(3*k), byte_of(3*k+1), byte_of(3*k+2)});
    stall = 0;
    for (int i = 0; i < 5; i++) begin
      rand_inputs(0);
      cycle();
    end
    chk("done_no_pops", total_pops, N_WORDS);
    bus.fifo_hw = 0; bus.fifo_lw = 1;
    cycle();
    chk("done_pause", bus.sdram_pause, 1'b1);
    chk("done_unpause", bus.sdram_unpause, 1'b0);

    // restart from DONE, watermarks, start ignored in LOAD, abort+start
    fill_fifo(800);
    wr_count = 0; first_wr_addr = -1;
    start_i = 1; cycle(); start_i = 0;
    chk("restart_busy", busy_o, 1'b1);
    chk("restart_done", done_o, 1'b0);
    stall = 1; bus.fifo_hw = 1; bus.fifo_lw = 1;
    cycle();
    chk("hw_pause", bus.sdram_pause, 1'b1);
    chk("hw_unpause", bus.sdram_unpause, 1'b0);
    bus.fifo_hw = 0; bus.fifo_lw = 1;
    cycle();
    chk("lw_pause", bus.sdram_pause, 1'b0);
    chk("lw_unpause", bus.sdram_unpause, 1'b1);
    n = 0;
    while (m_writes < 20 && n < 1000) begin
      rand_inputs(1);
      cycle();
      n++;
    end
    start_i = 1; cycle(); start_i = 0;
    chk("start_in_load_busy", busy_o, 1'b1);
    chk("restart_first_addr", first_wr_addr, 0);
    stall = 0; bus.fifo_hw = 0; bus.fifo_lw = 0;
    n = 0;
    while (!(m_writes >= 100 && (m_pops % 3) == 1) && n < 1000) begin
      cycle();
      n++;
    end
    chk("abort_point", m_writes >= 100, 1'b1);
    abort_i = 1; start_i = 1; cycle(); abort_i = 0; start_i = 0;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_no_we", bus.mem_we, 1'b0);
    cycle();
    chk("abort_idle_busy", busy_o, 1'b0);

    // fresh load after abort restarts at address 0, phase 0
    fill_fifo(12);
    wr_count = 0; first_wr_addr = -1;
    start_i = 1; cycle(); start_i = 0;
    n = 0;
    while (wr_count < 2 && n < 50) begin
      cycle();
      n++;
    end
    chk("reload_first_addr", first_wr_addr, 0);
    chk("reload_pixel0", tb_mem[0], {ld[0], ld[1][15:8]});
    chk("reload_pixel1", tb_mem[1], {ld[1][7:0], ld[2]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
